sram_mem_controller: RTL and testbench

- Memory-side responder for the MEM stage of the ARM pipeline: accepts one 32-bit read or write per request and performs it as two 16-bit accesses on an external asynchronous SRAM.
- Signals completion on `ready`. The pipeline uses ~ready as its freeze, so MEM_stage_reg samples `read_data` on the cycle `ready` returns high.

---
 rtl/arm_mem_pkg.sv | 23 ++
 rtl/sram_read_cache.sv | 42 ++++
 rtl/sram_mem_controller.sv | 141 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller and its address decoder.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC_LO,
        ST_ACC_HI,
        ST_DONE
    } state_e;

    localparam int          SRAM_ADDR_W = 18;
    localparam int          SRAM_DATA_W = 16;
    localparam int          WORD_W      = SRAM_ADDR_W - 1;
    localparam int unsigned BASE_ADDR   = 1024;

    // Pipeline byte address -> 17-bit SRAM word index (the halfword select is appended later).
    function automatic logic [WORD_W-1:0] word_of(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[WORD_W+1:2];
    endfunction

endpackage

// File: rtl/sram_read_cache.sv
// One-entry read cache for sram_mem_controller; only compiled when SRAM_CTRL_RD_CACHE_EN is defined.
`ifdef SRAM_CTRL_RD_CACHE_EN
module sram_read_cache
    import arm_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] lookup_word_i,
    output logic              hit_o,
    output logic [31:0]       data_o,
    input  logic              upd_i,
    input  logic              upd_wr_i,
    input  logic [WORD_W-1:0] upd_word_i,
    input  logic [31:0]       upd_data_i
);

    logic              valid_q;
    logic [WORD_W-1:0] tag_q;
    logic [31:0]       data_q;

    // Reads refill unconditionally; writes only keep a matching entry coherent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (upd_i) begin
            if (!upd_wr_i) begin
                valid_q <= 1'b1;
                tag_q   <= upd_word_i;
                data_q  <= upd_data_i;
            end else if (valid_q && tag_q == upd_word_i) begin
                data_q  <= upd_data_i;
            end
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_word_i);
    assign data_o = data_q;

endmodule
`endif

// File: rtl/sram_mem_controller.sv
// MEM-stage responder: one 32-bit access done as two held 16-bit SRAM accesses.
// Optional one-entry read cache enabled by defining SRAM_CTRL_RD_CACHE_EN.
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int          BIT_NUMBER = 32,
    parameter int          SRAM_WAIT  = 3,
    parameter int unsigned BASE_ADDR  = arm_mem_pkg::BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [BIT_NUMBER-1:0]  address,
    input  logic [BIT_NUMBER-1:0]  write_data,
    output logic [BIT_NUMBER-1:0]  read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam logic [3:0] LAST_CNT = 4'(SRAM_WAIT - 1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [WORD_W-1:0]       word_q;
    logic [BIT_NUMBER-1:0]   wdata_q, rdata_q;
    logic                    wr_q;
    logic                    req, hit, last, hi_half, accept;
    logic [WORD_W-1:0]       req_word;

    assign req      = rd_en | wr_en;
    assign last     = (cnt_q == LAST_CNT);
    assign hi_half  = (state_q == ST_ACC_HI);
    assign req_word = word_of(address, BASE_ADDR);
    assign accept   = (state_q == ST_IDLE) && req && !hit;

`ifdef SRAM_CTRL_RD_CACHE_EN
    logic                  c_hit;
    logic [BIT_NUMBER-1:0] c_data;

    sram_read_cache u_cache (
        .clk_i         (clk),
        .rst_i         (rst),
        .lookup_word_i (req_word),
        .hit_o         (c_hit),
        .data_o        (c_data),
        .upd_i         (state_q == ST_DONE),
        .upd_wr_i      (wr_q),
        .upd_word_i    (word_q),
        .upd_data_i    (wr_q ? wdata_q : rdata_q)
    );

    assign hit       = (state_q == ST_IDLE) && rd_en && !wr_en && c_hit;
    assign read_data = hit ? c_data : rdata_q;
`else
    assign hit       = 1'b0;
    assign read_data = rdata_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A cache hit lands in rdata_q so the value holds after the request drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                word_q  <= req_word;
                wdata_q <= write_data;
                wr_q    <= wr_en;
            end
            if (hit)
                rdata_q <= read_data;
            if (!wr_q && last && state_q == ST_ACC_LO)
                rdata_q[SRAM_DATA_W-1:0] <= sram_dq_in;
            if (!wr_q && last && state_q == ST_ACC_HI)
                rdata_q[BIT_NUMBER-1:SRAM_DATA_W] <= sram_dq_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = ST_ACC_LO;
            end
            ST_ACC_LO: if (last) begin
                state_d = ST_ACC_HI;
                cnt_d   = '0;
            end
            ST_ACC_HI: if (last) begin
                state_d = ST_DONE;
                cnt_d   = '0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Write strobe drops on the final phase cycle so it ends before the address moves.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        ready       = 1'b0;
        unique case (state_q)
            ST_IDLE: ready = !req || hit;
            ST_ACC_LO, ST_ACC_HI: begin
                sram_addr = {word_q, hi_half};
                if (wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = hi_half ? wdata_q[BIT_NUMBER-1:SRAM_DATA_W]
                                          : wdata_q[SRAM_DATA_W-1:0];
                    sram_we_n   = last;
                end
            end
            ST_DONE: ready = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: directed cases plus randomized traffic vs a word-level model.
module tb_sram_mem_controller;

    localparam int W   = 3;
    localparam int LAT = 2 * W + 1;
    localparam bit CACHE =
`ifdef SRAM_CTRL_RD_CACHE_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in, sram_dq_out;
    logic        sram_dq_oe, sram_we_n;

    sram_mem_controller #(.BIT_NUMBER(32), .SRAM_WAIT(W), .BASE_ADDR(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural async SRAM, with a preload port for the bench.
    logic [15:0] sram [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;

    assign sram_dq_in = sram[sram_addr[9:0]];

    always @(posedge clk) begin
        if (pl_en)
            sram[pl_addr] <= pl_data;
        else if (!sram_we_n && sram_dq_oe)
            sram[sram_addr[9:0]] <= sram_dq_out;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: contents, and which word a cache would hold.
    logic [31:0] ref_mem [0:63];
    bit          cv = 1'b0;
    int          cw = 0;

    function automatic int exp_lat(input bit is_wr, input int w);
        if (CACHE && !is_wr && cv && cw == w) return 0;
        return LAT;
    endfunction

    task automatic note(input bit is_wr, input int w);
        if (CACHE && !is_wr) begin
            cv = 1'b1;
            cw = w;
        end
    endtask

    task automatic pre_word(input int w, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 10'(w * 2); pl_data = d[15:0];
        @(negedge clk);
        pl_addr = 10'(w * 2 + 1); pl_data = d[31:16];
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[w] = d;
    endtask

    logic [17:0] tr_addr [0:63];
    logic        tr_we   [0:63];
    logic        tr_oe   [0:63];

    task automatic wait_ready(output int lat, output logic [31:0] q);
        lat = -1;
        q   = 'x;
        for (int c = 0; c < 64; c++) begin
            #1;
            tr_addr[c] = sram_addr; tr_we[c] = sram_we_n; tr_oe[c] = sram_dq_oe;
            if (ready) begin
                lat = c;
                q   = read_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int lat, output logic [31:0] q);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        wait_ready(lat, q);
        if (!hold) begin
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    initial begin
        int          lat, n_lo, n_hi, n_oe, w, e_lat;
        bit          ok, wr, rd;
        logic [31:0] q, last_rd, d;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        pre_word(0, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_rdata", read_data, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);

        // Plain read of halfwords 0/1
        txn(0, 1, 1024, 0, 0, lat, q);
        check("rd_lat", lat, LAT);
        check("rd_data", q, 32'hDEADBEEF);
        ok = 1'b1;
        for (int c = 1; c <= W; c++)
            ok &= (tr_addr[c] == 0) && !tr_oe[c] && tr_we[c];
        for (int c = W + 1; c <= 2 * W; c++)
            ok &= (tr_addr[c] == 1) && !tr_oe[c] && tr_we[c];
        check("rd_phases", ok, 1);
        note(0, 0);
        last_rd = q;

`ifdef SRAM_CTRL_RD_CACHE_EN
        txn(0, 1, 1024, 0, 0, lat, q);
        check("c_hit_lat", lat, 0);
        check("c_hit_data", q, 32'hDEADBEEF);
        check("c_hit_quiet", {tr_oe[0], tr_we[0]}, 2'b01);
        @(negedge clk); #1;
        check("c_hit_stay_idle", {ready, sram_dq_oe}, 2'b10);
        txn(1, 0, 1024, 32'h0, 0, lat, q);
        check("c_wr_lat", lat, LAT);
        ref_mem[0] = 32'h0;
        txn(0, 1, 1024, 0, 0, lat, q);
        check("c_upd_lat", lat, 0);
        check("c_upd_data", q, 32'h0);
        last_rd = q;
`endif

        // Write: strobe pattern per half and resulting halfwords
        txn(1, 0, 1028, 32'h12345678, 0, lat, q);
        check("wr_lat", lat, LAT);
        n_lo = 0; n_hi = 0; n_oe = 0;
        for (int c = 0; c <= lat && c < 64; c++) begin
            if (c >= 1 && c <= W && !tr_we[c]) n_lo++;
            if (c > W && c <= 2 * W && !tr_we[c]) n_hi++;
            if (tr_oe[c]) n_oe++;
        end
        check("wr_we_lo", n_lo, W - 1);
        check("wr_we_hi", n_hi, W - 1);
        check("wr_oe", n_oe, 2 * W);
        check("wr_hw2", sram[2], 16'h5678);
        check("wr_hw3", sram[3], 16'h1234);
        check("wr_rd_hold", q, last_rd);
        ref_mem[1] = 32'h12345678;

        // Both requests: write wins
        txn(1, 1, 1032, 32'hA5A5A5A5, 0, lat, q);
        check("sim_lat", lat, LAT);
        check("sim_mem", {sram[5], sram[4]}, 32'hA5A5A5A5);
        check("sim_rd_hold", q, last_rd);
        ref_mem[2] = 32'hA5A5A5A5;

        // Read then held write, back to back
        e_lat = exp_lat(0, 2);
        txn(0, 1, 1032, 0, 1, lat, q);
        check("b2b_rd_lat", lat, e_lat);
        check("b2b_rd_data", q, 32'hA5A5A5A5);
        note(0, 2);
        last_rd = q;
        rd_en = 1'b0; wr_en = 1'b1; address = 1036; write_data = 32'hCAFEF00D;
        @(negedge clk);
        wait_ready(lat, q);
        wr_en = 1'b0;
        check("b2b_gap", lat + 1, LAT + 1);
        check("b2b_phase", {tr_addr[1], tr_addr[W + 1]}, {18'd6, 18'd7});
        check("b2b_mem", {sram[7], sram[6]}, 32'hCAFEF00D);
        check("b2b_rd_hold", q, last_rd);
        ref_mem[3] = 32'hCAFEF00D;

        // Reset in the second ACC_HI cycle of a write
        @(negedge clk);
        wr_en = 1'b1; address = 1040; write_data = 32'h0F0F0F0F;
        repeat (W + 2) @(negedge clk);
        #1;
        check("pre_rst_we", sram_we_n, 0);
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_we_n", sram_we_n, 1);
        check("mid_rst_oe", sram_dq_oe, 0);
        check("mid_rst_addr", sram_addr, 0);
        check("mid_rst_rdata", read_data, 0);
        @(negedge clk);
        rst = 1'b0;
        cv = 1'b0;
        last_rd = '0;

        // Randomized traffic against the word model
        for (int i = 0; i < 64; i++)
            pre_word(i, $urandom());
        for (int i = 0; i < 80; i++) begin
            w  = int'($urandom_range(0, 63));
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = $urandom();
            e_lat = exp_lat(wr, w);
            txn(wr, rd, 32'(1024 + 4 * w), d, 0, lat, q);
            check("rnd_lat", lat, e_lat);
            if (wr) begin
                check("rnd_wr_hold", q, last_rd);
                ref_mem[w] = d;
            end else begin
                check("rnd_rd", q, ref_mem[w]);
                last_rd = q;
            end
            note(wr, w);
        end
        @(negedge clk);
        for (int i = 0; i < 64; i++)
            check("rnd_mem", {sram[2 * i + 1], sram[2 * i]}, ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
